// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: status codes, length codes, FSM states and length decode shared by the memory controller.
package mem_ctrl_pkg;
    localparam logic [1:0] ST_INIT = 2'b00;
    localparam logic [1:0] ST_BUSY = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;
    localparam logic [1:0] LEN_BYTE = 2'd0;
    localparam logic [1:0] LEN_HALF = 2'd1;
    localparam logic [1:0] LEN_WORD = 2'd3;

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    // The illegal length code 2 is served as a full word.
    function automatic logic [2:0] len_to_n(input logic [1:0] len);
        return (len == LEN_WORD || len == 2'd2) ? 3'd4 : (len == LEN_HALF) ? 3'd2 : 3'd1;
    endfunction
endpackage

// File: rtl/mem_ctrl_arb.sv
// mem_ctrl_arb: combinational priority select between the load/store and fetch clients;
// load/store wins when both request.
module mem_ctrl_arb
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [1:0]        mem_len,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              valid,
    output logic              sel_mem,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic [2:0]        n,
    output logic [DATA_W-1:0] wdata
);
    assign valid   = mem_req | if_req;
    assign sel_mem = mem_req;
    assign we      = mem_req & mem_we;
    assign addr    = mem_req ? mem_addr : if_addr;
    assign n       = mem_req ? len_to_n(mem_len) : 3'd4;
    assign wdata   = mem_req ? mem_wdata : '0;
endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: serialises word fetches and byte/half/word loads and stores onto a byte-wide RAM port.
// Every output is registered from the next-state values so it lines up with the state it describes.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_readwrite,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [1:0]        if_status,
    output logic [DATA_W-1:0] if_data,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [1:0]        mem_len,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [1:0]        mem_status,
    output logic [DATA_W-1:0] mem_rdata,
    input  logic [7:0]        ram_din,
    output logic [7:0]        ram_dout,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr
);
    state_t              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d, n_q, n_d;
    logic [ADDR_W-1:0]   base_q, base_d, ram_a_q, ram_a_d;
    logic                sel_mem_q, sel_mem_d, ram_wr_q, ram_wr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d, asm_q, asm_d;
    logic [DATA_W-1:0]   if_data_q, if_data_d, mem_rdata_q, mem_rdata_d;
    logic [1:0]          if_status_q, if_status_d, mem_status_q, mem_status_d;
    logic [7:0]          ram_dout_q, ram_dout_d;
    logic                arb_valid, arb_sel_mem, arb_we;
    logic [ADDR_W-1:0]   arb_addr;
    logic [2:0]          arb_n;
    logic [DATA_W-1:0]   arb_wdata;
    logic                rd_fin, wr_fin, busy, done;

    mem_ctrl_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_arb (
        .if_req    (if_readwrite),
        .if_addr   (if_addr),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_len   (mem_len),
        .mem_wdata (mem_wdata),
        .valid     (arb_valid),
        .sel_mem   (arb_sel_mem),
        .we        (arb_we),
        .addr      (arb_addr),
        .n         (arb_n),
        .wdata     (arb_wdata)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        n_d       = n_q;
        base_d    = base_q;
        sel_mem_d = sel_mem_q;
        wdata_d   = wdata_q;
        asm_d     = asm_q;
        rd_fin    = state_q == READ && cnt_q == n_q;
        wr_fin    = state_q == WRITE && cnt_q == n_q - 3'd1;
        case (state_q)
            IDLE: if (arb_valid) begin
                state_d   = arb_we ? WRITE : READ;
                cnt_d     = 3'd0;
                n_d       = arb_n;
                base_d    = arb_addr;
                sel_mem_d = arb_sel_mem;
                wdata_d   = arb_wdata;
                asm_d     = '0;
            end
            READ: begin
                // ram_din carries the byte addressed one cycle earlier, i.e. lane cnt-1.
                if (cnt_q != 3'd0) asm_d = asm_q | (DATA_W'(ram_din) << {cnt_q - 3'd1, 3'b000});
                state_d = rd_fin ? DONE : READ;
                cnt_d   = rd_fin ? cnt_q : cnt_q + 3'd1;
            end
            WRITE: begin
                state_d = wr_fin ? DONE : WRITE;
                cnt_d   = wr_fin ? cnt_q : cnt_q + 3'd1;
            end
            default: state_d = IDLE;
        endcase
        busy         = state_d == READ || state_d == WRITE;
        done         = state_d == DONE;
        if_status_d  = sel_mem_d ? ST_INIT : busy ? ST_BUSY : done ? ST_DONE : ST_INIT;
        mem_status_d = !sel_mem_d ? ST_INIT : busy ? ST_BUSY : done ? ST_DONE : ST_INIT;
        if_data_d    = (rd_fin && !sel_mem_q) ? asm_d : if_data_q;
        mem_rdata_d  = (rd_fin && sel_mem_q) ? asm_d : mem_rdata_q;
        ram_wr_d     = state_d == WRITE;
        ram_a_d      = (state_d == WRITE || (state_d == READ && cnt_d < n_d)) ? base_d + ADDR_W'(cnt_d) : '0;
        ram_dout_d   = (state_d == WRITE) ? 8'(wdata_d >> {cnt_d, 3'b000}) : 8'h00;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            n_q          <= '0;
            base_q       <= '0;
            sel_mem_q    <= 1'b0;
            wdata_q      <= '0;
            asm_q        <= '0;
            if_status_q  <= ST_INIT;
            mem_status_q <= ST_INIT;
            if_data_q    <= '0;
            mem_rdata_q  <= '0;
            ram_wr_q     <= 1'b0;
            ram_a_q      <= '0;
            ram_dout_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            n_q          <= n_d;
            base_q       <= base_d;
            sel_mem_q    <= sel_mem_d;
            wdata_q      <= wdata_d;
            asm_q        <= asm_d;
            if_status_q  <= if_status_d;
            mem_status_q <= mem_status_d;
            if_data_q    <= if_data_d;
            mem_rdata_q  <= mem_rdata_d;
            ram_wr_q     <= ram_wr_d;
            ram_a_q      <= ram_a_d;
            ram_dout_q   <= ram_dout_d;
        end
    end

    assign if_status  = if_status_q;
    assign mem_status = mem_status_q;
    assign if_data    = if_data_q;
    assign mem_rdata  = mem_rdata_q;
    assign ram_wr     = ram_wr_q;
    assign ram_a      = ram_a_q;
    assign ram_dout   = ram_dout_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed scenarios against a byte RAM model with one-cycle read latency.
module tb_mem_ctrl;
    localparam logic [1:0] INIT = 2'b00, BUSY = 2'b01, DONE = 2'b10;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_readwrite = 1'b0;
    logic [31:0] if_addr = '0;
    logic [1:0]  if_status;
    logic [31:0] if_data;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [1:0]  mem_len = '0;
    logic [31:0] mem_wdata = '0;
    logic [1:0]  mem_status;
    logic [31:0] mem_rdata;
    logic [7:0]  ram_din = '0;
    logic [7:0]  ram_dout;
    logic [31:0] ram_a;
    logic        ram_wr;

    logic [7:0]  ram [1024];
    int          wr_cnt = 0;
    int          total = 0;
    int          passed = 0;

    mem_ctrl dut (
        .clk(clk), .rst(rst),
        .if_readwrite(if_readwrite), .if_addr(if_addr), .if_status(if_status), .if_data(if_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_len(mem_len),
        .mem_wdata(mem_wdata), .mem_status(mem_status), .mem_rdata(mem_rdata),
        .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr)
    );

    always #5 clk = ~clk;

    // RAM aliases on the low 10 address bits; enough to keep all test regions apart.
    always @(posedge clk) begin
        ram_din <= ram[ram_a[9:0]];
        if (ram_wr) ram[ram_a[9:0]] = ram_dout;
    end

    always @(posedge clk) if (ram_wr) wr_cnt <= wr_cnt + 1;

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++; if (if_status !== INIT) $display("FAIL reset_if_status got %h want %h", if_status, INIT); else passed++;
        total++; if (mem_status !== INIT) $display("FAIL reset_mem_status got %h want %h", mem_status, INIT); else passed++;
        total++; if (if_data !== 32'h0) $display("FAIL reset_if_data got %h want 0", if_data); else passed++;
        total++; if (mem_rdata !== 32'h0) $display("FAIL reset_mem_rdata got %h want 0", mem_rdata); else passed++;
        total++; if (ram_a !== 32'h0 || ram_wr !== 1'b0 || ram_dout !== 8'h0)
            $display("FAIL reset_ram got a=%h wr=%b dout=%h want 0/0/0", ram_a, ram_wr, ram_dout); else passed++;
        rst = 1'b1;
    endtask

    // Word fetch: k counts cycles after the accepting edge.
    task automatic test_fetch(input logic [31:0] a, input logic [31:0] exp_data, input string name);
        logic [1:0]  exp_st;
        logic [31:0] exp_a;
        @(negedge clk);
        if_readwrite = 1'b1;
        if_addr = a;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            exp_st = k <= 5 ? BUSY : k == 6 ? DONE : INIT;
            exp_a  = k <= 4 ? a + 32'(k - 1) : 32'h0;
            total++; if (if_status !== exp_st) $display("FAIL %s_status k=%0d got %h want %h", name, k, if_status, exp_st); else passed++;
            total++; if (ram_a !== exp_a) $display("FAIL %s_ram_a k=%0d got %h want %h", name, k, ram_a, exp_a); else passed++;
            total++; if (ram_wr !== 1'b0) $display("FAIL %s_ram_wr k=%0d got %b want 0", name, k, ram_wr); else passed++;
            if (k == 6) begin
                total++; if (if_data !== exp_data) $display("FAIL %s_data got %h want %h", name, if_data, exp_data); else passed++;
            end
            if (k == 1) if_readwrite = 1'b0;
        end
    endtask

    task automatic test_store_word();
        logic [31:0] wd;
        wd = 32'hDEADBEEF;
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'd3; mem_addr = 32'h200; mem_wdata = wd;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k <= 4) begin
                total++; if (ram_wr !== 1'b1 || ram_a !== 32'h200 + 32'(k - 1) || ram_dout !== wd[8*(k-1) +: 8])
                    $display("FAIL store_beat k=%0d got wr=%b a=%h d=%h want 1/%h/%h", k, ram_wr, ram_a, ram_dout,
                             32'h200 + 32'(k - 1), wd[8*(k-1) +: 8]); else passed++;
                total++; if (mem_status !== BUSY) $display("FAIL store_busy k=%0d got %h want %h", k, mem_status, BUSY); else passed++;
            end else begin
                total++; if (ram_wr !== 1'b0 || ram_dout !== 8'h0) $display("FAIL store_idle_ram k=%0d got wr=%b d=%h want 0/0", k, ram_wr, ram_dout); else passed++;
                total++; if (mem_status !== (k == 5 ? DONE : INIT))
                    $display("FAIL store_status k=%0d got %h want %h", k, mem_status, k == 5 ? DONE : INIT); else passed++;
            end
            if (k == 1) mem_req = 1'b0;
        end
    endtask

    task automatic test_load_byte();
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'd0; mem_addr = 32'h203;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            total++; if (mem_status !== (k <= 2 ? BUSY : k == 3 ? DONE : INIT))
                $display("FAIL load_byte_status k=%0d got %h want %h", k, mem_status, k <= 2 ? BUSY : k == 3 ? DONE : INIT); else passed++;
            if (k >= 3) begin
                total++; if (mem_rdata !== 32'h000000DE) $display("FAIL load_byte_data k=%0d got %h want 000000de", k, mem_rdata); else passed++;
            end
            if (k == 1) mem_req = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        if_readwrite = 1'b1; if_addr = 32'h100;
        mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'd1; mem_addr = 32'h200;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (k <= 5) begin
                total++; if (if_status !== INIT) $display("FAIL b2b_if_waits k=%0d got %h want %h", k, if_status, INIT); else passed++;
            end
            if (k == 4) begin
                total++; if (mem_status !== DONE || mem_rdata !== 32'h0000BEEF)
                    $display("FAIL b2b_mem_done got st=%h d=%h want %h/0000beef", mem_status, mem_rdata, DONE); else passed++;
            end
            if (k == 6) begin
                total++; if (if_status !== BUSY) $display("FAIL b2b_if_busy got %h want %h", if_status, BUSY); else passed++;
                if_readwrite = 1'b0;
            end
            if (k == 11) begin
                total++; if (if_status !== DONE || if_data !== 32'h00A00513)
                    $display("FAIL b2b_if_done got st=%h d=%h want %h/00a00513", if_status, if_data, DONE); else passed++;
            end
            if (k == 1) mem_req = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_write();
        int snap;
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'd3; mem_addr = 32'h300; mem_wdata = 32'h11223344;
        @(negedge clk);
        mem_req = 1'b0;
        @(negedge clk);
        total++; if (ram_wr !== 1'b1 || ram_a !== 32'h301) $display("FAIL rst_pre got wr=%b a=%h want 1/301", ram_wr, ram_a); else passed++;
        rst = 1'b0;
        #1;
        snap = wr_cnt;
        total++; if (ram_wr !== 1'b0) $display("FAIL rst_async_wr got %b want 0", ram_wr); else passed++;
        total++; if (if_status !== INIT || mem_status !== INIT)
            $display("FAIL rst_async_status got if=%h mem=%h want 0/0", if_status, mem_status); else passed++;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (8) @(negedge clk);
        total++; if (wr_cnt !== snap) $display("FAIL rst_no_more_writes got %0d want %0d", wr_cnt, snap); else passed++;
        total++; if (ram[10'h300] !== 8'h44 || ram[10'h301] !== 8'h00)
            $display("FAIL rst_ram_contents got %h %h want 44 00", ram[10'h300], ram[10'h301]); else passed++;
        test_fetch(32'h100, 32'h00A00513, "post_rst_fetch");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
        ram[10'h100] = 8'h13; ram[10'h101] = 8'h05; ram[10'h102] = 8'hA0; ram[10'h103] = 8'h00;
        ram[10'h3FE] = 8'h11; ram[10'h3FF] = 8'h22; ram[10'h000] = 8'h33; ram[10'h001] = 8'h44;
        test_reset();
        test_fetch(32'h100, 32'h00A00513, "fetch");
        test_store_word();
        test_load_byte();
        test_back_to_back();
        test_reset_mid_write();
        test_fetch(32'hFFFFFFFE, 32'h44332211, "wrap");
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
